// File: rtl/fan_speed.sv
// fan_speed: fixed-frequency PWM generator for the fan-motor enable.
// A free-running period counter walks slots 0..2**WIDTH-1; the requested speed
// is latched only on the wrap edge, so a period always completes with the duty
// it started with and no runt pulses can appear.

module fan_speed #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             arst,      // synchronous, active-high despite the name
   input  logic [WIDTH-1:0] speed,
   output logic             pwm_data
);

   localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] duty_q, duty_d;
   logic             pwm_q, pwm_d;
   logic             boundary;

   assign boundary = (cnt_q == CNT_MAX);

   // Next-state: wrap and latch speed at the boundary, otherwise advance and hold duty.
   always_comb begin
      cnt_d  = cnt_q;
      duty_d = duty_q;
      if (boundary) begin
         cnt_d  = '0;
         duty_d = speed;
      end else begin
         cnt_d  = cnt_q + 1'b1;
      end
      // Compare against the values being loaded so the output lines up with the slot.
      pwm_d = (cnt_d < duty_d);
   end

   // State registers; reset parks the counter at MAX so the first live edge is slot 0.
   always_ff @(posedge clk) begin
      if (arst) begin
         cnt_q  <= CNT_MAX;
         duty_q <= '0;
         pwm_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         duty_q <= duty_d;
         pwm_q  <= pwm_d;
      end
   end

   assign pwm_data = pwm_q;

endmodule

// File: tb/tb_fan_speed.sv
// tb_fan_speed: directed checks of the fan PWM generator (WIDTH = 8).

module tb_fan_speed;

   logic       clk;
   logic       arst;
   logic [7:0] speed;
   logic       pwm_data;

   int checks;
   int failures;

   fan_speed #(.WIDTH(8)) dut (
      .clk      (clk),
      .arst     (arst),
      .speed    (speed),
      .pwm_data (pwm_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle to the sample point.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Observe one full period starting at slot 0. Optionally change speed just
   // before the edge that produces slot change_at (negative = no change).
   task automatic measure_period(input int change_at, input logic [7:0] new_speed,
                                 output int highs, output bit contiguous, output logic first);
      bit seen_low;
      highs      = 0;
      contiguous = 1'b1;
      seen_low   = 1'b0;
      first      = 1'bx;
      for (int i = 0; i < 256; i++) begin
         if (i == change_at) speed = new_speed;
         step();
         if (i == 0) first = pwm_data;
         if (pwm_data === 1'b1) begin
            highs++;
            if (seen_low) contiguous = 1'b0;
         end else if (pwm_data === 1'b0) begin
            seen_low = 1'b1;
         end else begin
            contiguous = 1'b0;
         end
      end
   endtask

   // Hold reset for five edges with the given speed, then release before the next edge.
   task automatic do_reset(input logic [7:0] spd);
      arst  = 1'b1;
      speed = spd;
      repeat (5) step();
      arst = 1'b0;
   endtask

   task automatic test_reset();
      int   highs;
      bit   contig;
      logic first;
      arst  = 1'b1;
      speed = 8'h80;
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if (pwm_data !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold cycle %0d: got %b want 0", i, pwm_data);
         end
      end
      arst = 1'b0;
      measure_period(-1, 8'h00, highs, contig, first);
      checks++;
      if (first !== 1'b1) begin
         failures++;
         $display("FAIL reset_release_first: got %b want 1", first);
      end
      checks++;
      if (highs != 128 || !contig) begin
         failures++;
         $display("FAIL reset_release_period: got highs=%0d contig=%0d want 128/1", highs, contig);
      end
   endtask

   task automatic test_low_zero();
      int   highs;
      bit   contig;
      logic first;
      do_reset(8'h01);
      for (int p = 0; p < 2; p++) begin
         measure_period(-1, 8'h00, highs, contig, first);
         checks++;
         if (highs != 1 || !contig || first !== 1'b1) begin
            failures++;
            $display("FAIL duty_01 period %0d: got highs=%0d contig=%0d first=%b want 1/1/1",
                     p, highs, contig, first);
         end
      end
      do_reset(8'h00);
      for (int p = 0; p < 3; p++) begin
         measure_period(-1, 8'h00, highs, contig, first);
         checks++;
         if (highs != 0 || first !== 1'b0) begin
            failures++;
            $display("FAIL duty_00 period %0d: got highs=%0d first=%b want 0/0", p, highs, first);
         end
      end
   endtask

   task automatic test_typical();
      logic [7:0] codes [3];
      int         highs;
      bit         contig;
      logic       first;
      codes[0] = 8'h0D;
      codes[1] = 8'h80;
      codes[2] = 8'h71;
      do_reset(codes[0]);
      for (int c = 0; c < 3; c++) begin
         for (int p = 0; p < 3; p++) begin
            // New code is captured exactly on the boundary edge of the first period.
            if (p == 0 && c != 0) measure_period(0, codes[c], highs, contig, first);
            else                  measure_period(-1, 8'h00, highs, contig, first);
            checks++;
            if (highs != int'(codes[c]) || !contig || first !== 1'b1) begin
               failures++;
               $display("FAIL duty_%h period %0d: got highs=%0d contig=%0d first=%b want %0d/1/1",
                        codes[c], p, highs, contig, first, codes[c]);
            end
         end
      end
   endtask

   task automatic test_mid_change();
      int   highs;
      bit   contig;
      logic first;
      do_reset(8'h0F);
      measure_period(128, 8'h49, highs, contig, first);
      checks++;
      if (highs != 15 || !contig) begin
         failures++;
         $display("FAIL mid_change_current: got highs=%0d contig=%0d want 15/1", highs, contig);
      end
      measure_period(-1, 8'h00, highs, contig, first);
      checks++;
      if (highs != 73 || !contig) begin
         failures++;
         $display("FAIL mid_change_next: got highs=%0d contig=%0d want 73/1", highs, contig);
      end
   endtask

   task automatic test_extremes_reset();
      int   highs;
      bit   contig;
      logic first;
      do_reset(8'hFF);
      for (int p = 0; p < 2; p++) begin
         measure_period(-1, 8'h00, highs, contig, first);
         checks++;
         if (highs != 255 || !contig) begin
            failures++;
            $display("FAIL duty_ff period %0d: got highs=%0d contig=%0d want 255/1", p, highs, contig);
         end
      end
      do_reset(8'h80);
      repeat (101) step();   // now at slot 100
      checks++;
      if (pwm_data !== 1'b1) begin
         failures++;
         $display("FAIL slot100_high: got %b want 1", pwm_data);
      end
      arst = 1'b1;
      step();
      checks++;
      if (pwm_data !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset_output: got %b want 0", pwm_data);
      end
      arst = 1'b0;
      measure_period(-1, 8'h00, highs, contig, first);
      checks++;
      if (highs != 128 || !contig || first !== 1'b1) begin
         failures++;
         $display("FAIL mid_reset_resume: got highs=%0d contig=%0d first=%b want 128/1/1",
                  highs, contig, first);
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      arst     = 1'b1;
      speed    = 8'h00;
      test_reset();
      test_low_zero();
      test_typical();
      test_mid_change();
      test_extremes_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
